lv_owt_tx_arb: RTL and testbench
================================

LV_OWT_TX_ARB -- requirements
Module: lv_owt_tx_arb

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, width of a one-wire transmit command word.
REQ-002 SHALL have parameter TMO_CYC, default 255, the number of cycles to wait for a transmit ack before timing out (legal range 2..1023).
REQ-003 SHALL have parameter GAP_CYC, default 4, the number of idle cycles forced between transactions (legal range 1..15).
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
REQ-005 SHALL have the remaining ports:
- i_owt_com_en  in  1  one-wire transmit enable from the LV control FSM.
- i_fsm_req  in  1  watchdog/status transmit request from the FSM; level signal, held until acked.
- i_fsm_data  in  DATA_W  command word for the FSM request.
- i_spi_req  in  1  SPI-forwarded transmit request; level signal.
- i_spi_data  in  DATA_W  command word for the SPI request.
- i_poll_req  in  1  periodic HV status poll request; level signal.
- i_poll_data  in  DATA_W  command word for the poll request.
- o_fsm_ack / o_spi_ack / o_poll_ack  out  1 each  one-cycle completion pulse to the matching requester.
- o_tx_req  out  1  transmit request to the OWT engine.
- o_tx_data  out  DATA_W  latched command word for the OWT engine.
- i_tx_ack  in  1  one-cycle completion pulse from the OWT engine.
- o_tmo_err  out  1  one-cycle pulse when a transaction times out.
- o_busy  out  1  high when the arbiter is not IDLE.
- o_grant_id  out  2  current owner: 0 none, 1 FSM, 2 SPI, 3 POLL.

Function
REQ-006 SHALL implement an FSM with states IDLE, WAIT_ACK and GAP; it SHALL reset to IDLE.
REQ-007 In IDLE with i_owt_com_en=1 and any request high, the arbiter SHALL select a winner.
- FSM requests have fixed highest priority.
- SPI and POLL share round-robin priority.
REQ-008 The round-robin pointer SHALL favour the requester not served most recently; its reset value SHALL favour SPI.
REQ-009 The pointer SHALL update only on a successful ack to SPI or POLL, never on a timeout or an abort.
REQ-010 On selection in cycle N, the arbiter SHALL latch the winner's data into o_tx_data and set o_grant_id; at N+1 it SHALL drive o_tx_req=1 and enter WAIT_ACK.
REQ-011 o_tx_data and o_grant_id SHALL stay stable while o_tx_req=1; the requester's data inputs are not sampled again.
REQ-012 In WAIT_ACK, i_tx_ack=1 in cycle M SHALL produce the following at M+1:
- o_tx_req=0;
- a one-cycle ack pulse on the granted requester only;
- entry to GAP.
REQ-013 The timeout counter SHALL start at 0 in the first cycle o_tx_req=1 and increment each WAIT_ACK cycle.
REQ-014 If TMO_CYC cycles pass in WAIT_ACK with no ack, the following cycle SHALL have:
- o_tx_req=0;
- o_tmo_err=1 for one cycle;
- no requester ack;
- entry to GAP.
REQ-015 If i_tx_ack arrives in the same cycle the timeout expires, the ack SHALL win and o_tmo_err SHALL stay 0.
REQ-016 GAP SHALL last exactly GAP_CYC cycles, then return to IDLE; no arbitration takes place in GAP.
REQ-017 A requester that still holds its request after a timeout SHALL be re-arbitrated normally once the arbiter is back in IDLE.
REQ-018 If a requester drops its request during WAIT_ACK, the transaction SHALL continue and its ack SHALL still be pulsed.
REQ-019 i_owt_com_en=0 in any state SHALL force the following at the next cycle:
- state IDLE;
- o_tx_req=0, o_grant_id=0;
- counters cleared;
- no ack and no o_tmo_err.
REQ-020 While i_owt_com_en=0, no arbitration SHALL take place.
REQ-021 i_tx_ack outside WAIT_ACK SHALL be ignored.
REQ-022 At most one ack output SHALL be high in any cycle.
REQ-023 o_tmo_err SHALL never be high in the same cycle as any ack output.
REQ-024 o_busy SHALL be 1 in WAIT_ACK and GAP and 0 in IDLE.
REQ-025 Every output SHALL be registered.
REQ-026 Counter widths SHALL be ceil(log2(max+1)) of their parameter; they SHALL never wrap.

Reset
REQ-027 With i_rst=1 at a clock edge, all of the following SHALL hold by the next cycle:
- state IDLE;
- o_tx_req=0, o_tx_data=0, o_grant_id=0;
- all acks 0, o_tmo_err=0, o_busy=0;
- counters 0;
- round-robin pointer to SPI.
REQ-028 Reset asserted in the middle of a transaction SHALL abort it with no ack and no o_tmo_err pulse.

Verification
REQ-029 Single request: en=1, i_spi_req=1 with data 16'hA55A at cycle 0 -> cycle 1 o_tx_req=1, o_tx_data=16'hA55A, o_grant_id=2. Then i_tx_ack at cycle 5 -> cycle 6 o_spi_ack=1, o_tx_req=0; o_busy falls at cycle 10 (GAP_CYC=4).
REQ-030 Priority: fsm, spi and poll requests all high continuously -> grant order FSM, FSM... while FSM is held. After the FSM request is released, grants alternate SPI, POLL, SPI.
REQ-031 Timeout: TMO_CYC=8, grant FSM, no ack -> o_tx_req high for exactly 8 cycles, then one o_tmo_err pulse, no o_fsm_ack; the FSM is re-granted after GAP.
REQ-032 Ack and timeout in the same cycle -> one ack pulse, o_tmo_err stays 0.
REQ-033 Enable drop: i_owt_com_en->0 during WAIT_ACK -> next cycle o_tx_req=0, o_busy=0, no pulses. A later i_tx_ack is ignored.
REQ-034 Reset mid-GAP with the POLL request pending -> after i_rst falls, the first grant goes to the pending requester per the reset pointer (SPI if both SPI and POLL are pending).

Source files
------------

// File: rtl/lv_owt_tx_arb_if.sv
// Requester / OWT-engine bundle for the one-wire transmit arbiter.
// slave: arbiter view. master: requesters plus OWT engine view.
interface lv_owt_tx_arb_if #(
    parameter int DATA_W = 16
);
    logic              i_owt_com_en;
    logic              i_fsm_req;
    logic [DATA_W-1:0] i_fsm_data;
    logic              i_spi_req;
    logic [DATA_W-1:0] i_spi_data;
    logic              i_poll_req;
    logic [DATA_W-1:0] i_poll_data;
    logic              o_fsm_ack;
    logic              o_spi_ack;
    logic              o_poll_ack;
    logic              o_tx_req;
    logic [DATA_W-1:0] o_tx_data;
    logic              i_tx_ack;
    logic              o_tmo_err;
    logic              o_busy;
    logic [1:0]        o_grant_id;

    modport slave (
        input  i_owt_com_en, i_fsm_req, i_fsm_data, i_spi_req, i_spi_data,
               i_poll_req, i_poll_data, i_tx_ack,
        output o_fsm_ack, o_spi_ack, o_poll_ack, o_tx_req, o_tx_data,
               o_tmo_err, o_busy, o_grant_id
    );

    modport master (
        output i_owt_com_en, i_fsm_req, i_fsm_data, i_spi_req, i_spi_data,
               i_poll_req, i_poll_data, i_tx_ack,
        input  o_fsm_ack, o_spi_ack, o_poll_ack, o_tx_req, o_tx_data,
               o_tmo_err, o_busy, o_grant_id
    );
endinterface

// File: rtl/lv_owt_tx_arb.sv
// One-wire transmit arbiter: FSM requests win outright, SPI and POLL share
// round-robin. One transaction at a time, with an ack timeout and a forced
// idle gap. All outputs come straight from flops.
module lv_owt_tx_arb #(
    parameter int DATA_W  = 16,
    parameter int TMO_CYC = 255,
    parameter int GAP_CYC = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    lv_owt_tx_arb_if.slave    bus
);
    localparam int TCW = $clog2(TMO_CYC + 1);
    localparam int GCW = $clog2(GAP_CYC + 1);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TMO_CYC - 1);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, GAP} state_t;

    state_t            state, nxt_state;
    logic              tx_req_q, nxt_tx_req;
    logic [DATA_W-1:0] tx_data_q, nxt_tx_data;
    logic [1:0]        gid_q, nxt_gid;
    logic [2:0]        ack_q, nxt_ack;     // {poll, spi, fsm}
    logic              tmo_q, nxt_tmo;
    logic              busy_q;
    logic [TCW-1:0]    tcnt_q, nxt_tcnt;
    logic [GCW-1:0]    gcnt_q, nxt_gcnt;
    logic              rr_poll_q, nxt_rr_poll;  // 1: POLL favoured over SPI

    // State, counters and every output register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            tx_req_q  <= 1'b0;
            tx_data_q <= '0;
            gid_q     <= 2'd0;
            ack_q     <= 3'b000;
            tmo_q     <= 1'b0;
            busy_q    <= 1'b0;
            tcnt_q    <= '0;
            gcnt_q    <= '0;
            rr_poll_q <= 1'b0;
        end else begin
            state     <= nxt_state;
            tx_req_q  <= nxt_tx_req;
            tx_data_q <= nxt_tx_data;
            gid_q     <= nxt_gid;
            ack_q     <= nxt_ack;
            tmo_q     <= nxt_tmo;
            busy_q    <= (nxt_state != IDLE);
            tcnt_q    <= nxt_tcnt;
            gcnt_q    <= nxt_gcnt;
            rr_poll_q <= nxt_rr_poll;
        end
    end

    // Next-state, arbitration, ack/timeout and counter logic.
    always_comb begin
        nxt_state   = state;
        nxt_tx_req  = tx_req_q;
        nxt_tx_data = tx_data_q;
        nxt_gid     = gid_q;
        nxt_ack     = 3'b000;
        nxt_tmo     = 1'b0;
        nxt_tcnt    = tcnt_q;
        nxt_gcnt    = gcnt_q;
        nxt_rr_poll = rr_poll_q;
        if (!bus.i_owt_com_en) begin
            // Abort: no pulses, pointer untouched.
            nxt_state  = IDLE;
            nxt_tx_req = 1'b0;
            nxt_gid    = 2'd0;
            nxt_tcnt   = '0;
            nxt_gcnt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.i_fsm_req) begin
                        nxt_gid     = 2'd1;
                        nxt_tx_data = bus.i_fsm_data;
                    end else if (bus.i_spi_req && (!bus.i_poll_req || !rr_poll_q)) begin
                        nxt_gid     = 2'd2;
                        nxt_tx_data = bus.i_spi_data;
                    end else if (bus.i_poll_req) begin
                        nxt_gid     = 2'd3;
                        nxt_tx_data = bus.i_poll_data;
                    end
                    if (bus.i_fsm_req || bus.i_spi_req || bus.i_poll_req) begin
                        nxt_state  = WAIT_ACK;
                        nxt_tx_req = 1'b1;
                        nxt_tcnt   = '0;
                    end
                end
                WAIT_ACK: begin
                    // Ack beats a timeout expiring in the same cycle.
                    if (bus.i_tx_ack) begin
                        unique case (gid_q)
                            2'd1:    nxt_ack = 3'b001;
                            2'd2:    begin nxt_ack = 3'b010; nxt_rr_poll = 1'b1; end
                            2'd3:    begin nxt_ack = 3'b100; nxt_rr_poll = 1'b0; end
                            default: nxt_ack = 3'b000;
                        endcase
                        nxt_state  = GAP;
                        nxt_tx_req = 1'b0;
                        nxt_gid    = 2'd0;
                        nxt_gcnt   = '0;
                    end else if (tcnt_q == TMO_LAST) begin
                        nxt_tmo    = 1'b1;
                        nxt_state  = GAP;
                        nxt_tx_req = 1'b0;
                        nxt_gid    = 2'd0;
                        nxt_gcnt   = '0;
                    end else begin
                        nxt_tcnt = tcnt_q + TCW'(1);
                    end
                end
                GAP: begin
                    if (gcnt_q == GAP_LAST) begin
                        nxt_state = IDLE;
                        nxt_gcnt  = '0;
                    end else begin
                        nxt_gcnt = gcnt_q + GCW'(1);
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    assign bus.o_tx_req   = tx_req_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_grant_id = gid_q;
    assign bus.o_fsm_ack  = ack_q[0];
    assign bus.o_spi_ack  = ack_q[1];
    assign bus.o_poll_ack = ack_q[2];
    assign bus.o_tmo_err  = tmo_q;
    assign bus.o_busy     = busy_q;
endmodule

// File: tb/tb_lv_owt_tx_arb.sv
// Bench for lv_owt_tx_arb: per-cycle vector table plus directed sequences
// for timeout, ack/timeout collision, priority and reset mid-gap.
module tb_lv_owt_tx_arb;
    localparam int DW = 16;

    logic i_clk = 1'b0;
    logic i_rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 i_clk = ~i_clk;

    lv_owt_tx_arb_if #(.DATA_W(DW)) bus ();

    lv_owt_tx_arb #(.DATA_W(DW), .TMO_CYC(8), .GAP_CYC(4)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic rst, en, f, s, p, ack;
        logic [DW-1:0] sd;
    } vin_t;
    typedef struct packed {
        logic          req;
        logic [DW-1:0] data;
        logic [1:0]    gid;
        logic [2:0]    acks;   // {poll, spi, fsm}
        logic          tmo, busy;
    } vout_t;
    typedef struct packed {
        vin_t  i;
        vout_t o;
    } vec_t;

    vec_t vecs [0:19];

    function automatic vec_t mk(input logic rst, en, f, s, p, ack, input logic [DW-1:0] sd,
                                input logic req, input logic [DW-1:0] data, input logic [1:0] gid,
                                input logic [2:0] acks, input logic tmo, busy);
        vec_t v;
        v.i = {rst, en, f, s, p, ack, sd};
        v.o = {req, data, gid, acks, tmo, busy};
        return v;
    endfunction

    function automatic vout_t sample();
        return {bus.o_tx_req, bus.o_tx_data, bus.o_grant_id,
                {bus.o_poll_ack, bus.o_spi_ack, bus.o_fsm_ack}, bus.o_tmo_err, bus.o_busy};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        bus.i_owt_com_en = 1'b0;
        bus.i_fsm_req = 1'b0;
        bus.i_spi_req = 1'b0;
        bus.i_poll_req = 1'b0;
        bus.i_tx_ack = 1'b0;
        step();
        step();
        i_rst = 1'b0;
    endtask

    // Wait for the next grant, check its owner, ack it and check the pulse.
    task automatic serve(input logic [1:0] exp_gid, input string name);
        int k = 0;
        while (!bus.o_tx_req && k < 20) begin
            step();
            k++;
        end
        chk({name, "_gid"}, 32'(bus.o_grant_id), 32'(exp_gid));
        bus.i_tx_ack = 1'b1;
        step();
        bus.i_tx_ack = 1'b0;
        chk({name, "_ack"}, 32'({bus.o_poll_ack, bus.o_spi_ack, bus.o_fsm_ack}),
            32'(3'b001 << (exp_gid - 2'd1)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_hi, n_tmo, n_fack, k;
        vout_t act;
        bus.i_fsm_data  = 16'h1111;
        bus.i_poll_data = 16'h0F0F;
        bus.i_spi_data  = 16'hA55A;

        //            rst en f s p ack sd        req data      gid acks    tmo busy
        vecs[0]  = mk(1, 0, 0,0,0, 0, 16'hA55A, 0, 16'h0000, 0, 3'b000, 0, 0);
        vecs[1]  = mk(1, 1, 0,1,0, 0, 16'hA55A, 0, 16'h0000, 0, 3'b000, 0, 0);
        vecs[2]  = mk(0, 1, 0,1,0, 0, 16'hA55A, 1, 16'hA55A, 2, 3'b000, 0, 1);
        vecs[3]  = mk(0, 1, 0,1,0, 0, 16'hBEEF, 1, 16'hA55A, 2, 3'b000, 0, 1);
        vecs[4]  = mk(0, 1, 0,0,0, 0, 16'hBEEF, 1, 16'hA55A, 2, 3'b000, 0, 1);
        vecs[5]  = mk(0, 1, 0,0,0, 1, 16'hBEEF, 0, 16'hA55A, 0, 3'b010, 0, 1);
        vecs[6]  = mk(0, 1, 0,1,0, 1, 16'hBEEF, 0, 16'hA55A, 0, 3'b000, 0, 1);
        vecs[7]  = mk(0, 1, 0,1,0, 0, 16'hBEEF, 0, 16'hA55A, 0, 3'b000, 0, 1);
        vecs[8]  = mk(0, 1, 0,1,0, 0, 16'hBEEF, 0, 16'hA55A, 0, 3'b000, 0, 1);
        vecs[9]  = mk(0, 1, 0,1,0, 0, 16'hBEEF, 0, 16'hA55A, 0, 3'b000, 0, 0);
        vecs[10] = mk(0, 1, 0,1,1, 0, 16'hBEEF, 1, 16'h0F0F, 3, 3'b000, 0, 1);
        vecs[11] = mk(0, 0, 0,1,1, 0, 16'hBEEF, 0, 16'h0F0F, 0, 3'b000, 0, 0);
        vecs[12] = mk(0, 0, 0,1,1, 1, 16'hBEEF, 0, 16'h0F0F, 0, 3'b000, 0, 0);
        vecs[13] = mk(0, 1, 0,1,1, 0, 16'hBEEF, 1, 16'h0F0F, 3, 3'b000, 0, 1);
        vecs[14] = mk(0, 1, 0,1,1, 1, 16'hBEEF, 0, 16'h0F0F, 0, 3'b100, 0, 1);
        vecs[15] = mk(0, 1, 0,1,1, 0, 16'hBEEF, 0, 16'h0F0F, 0, 3'b000, 0, 1);
        vecs[16] = mk(0, 1, 0,1,1, 0, 16'hBEEF, 0, 16'h0F0F, 0, 3'b000, 0, 1);
        vecs[17] = mk(0, 1, 0,1,1, 0, 16'hBEEF, 0, 16'h0F0F, 0, 3'b000, 0, 1);
        vecs[18] = mk(0, 1, 0,1,1, 0, 16'hBEEF, 0, 16'h0F0F, 0, 3'b000, 0, 0);
        vecs[19] = mk(0, 1, 1,1,1, 0, 16'hBEEF, 1, 16'h1111, 1, 3'b000, 0, 1);

        // Each vector's inputs are sampled at one edge; its outputs checked just after.
        for (int i = 0; i < 20; i++) begin
            i_rst            = vecs[i].i.rst;
            bus.i_owt_com_en = vecs[i].i.en;
            bus.i_fsm_req    = vecs[i].i.f;
            bus.i_spi_req    = vecs[i].i.s;
            bus.i_poll_req   = vecs[i].i.p;
            bus.i_tx_ack     = vecs[i].i.ack;
            bus.i_spi_data   = vecs[i].i.sd;
            step();
            act = sample();
            chk($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].o));
        end

        // Timeout: FSM granted, never acked.
        do_reset();
        bus.i_owt_com_en = 1'b1;
        bus.i_fsm_req = 1'b1;
        step();
        n_hi = 0; n_tmo = 0; n_fack = 0; k = 0;
        while (k < 30 && n_tmo == 0) begin
            if (bus.o_tx_req) n_hi++;
            step();
            k++;
            if (bus.o_tmo_err) n_tmo++;
            if (bus.o_fsm_ack) n_fack++;
        end
        chk("tmo_req_cycles", 32'(n_hi), 32'd8);
        chk("tmo_pulse", 32'(n_tmo), 32'd1);
        chk("tmo_no_ack", 32'(n_fack), 32'd0);
        step();
        chk("tmo_one_cycle", 32'(bus.o_tmo_err), 32'd0);
        k = 1;
        while (!bus.o_tx_req && k < 20) begin
            step();
            k++;
        end
        chk("tmo_regrant_delay", 32'(k), 32'd5);
        chk("tmo_regrant_gid", 32'(bus.o_grant_id), 32'd1);

        // Ack arrives in the cycle the timeout expires.
        do_reset();
        bus.i_owt_com_en = 1'b1;
        bus.i_spi_req = 1'b1;
        step();
        for (int j = 0; j < 7; j++) step();
        bus.i_tx_ack = 1'b1;
        step();
        bus.i_tx_ack = 1'b0;
        chk("race_ack", 32'(bus.o_spi_ack), 32'd1);
        chk("race_tmo", 32'(bus.o_tmo_err), 32'd0);
        chk("race_req", 32'(bus.o_tx_req), 32'd0);

        // Reset mid-gap: pointer returns to SPI even though SPI was served last.
        bus.i_poll_req = 1'b1;
        i_rst = 1'b1;
        step();
        chk("gaprst_out", 32'(sample()), 32'({1'b0, 16'h0000, 2'd0, 3'b000, 1'b0, 1'b0}));
        i_rst = 1'b0;
        step();
        chk("gaprst_gid", 32'(bus.o_grant_id), 32'd2);

        // Priority: FSM held wins twice, then SPI/POLL alternate.
        do_reset();
        bus.i_owt_com_en = 1'b1;
        bus.i_fsm_req = 1'b1;
        bus.i_spi_req = 1'b1;
        bus.i_poll_req = 1'b1;
        serve(2'd1, "pri_fsm0");
        serve(2'd1, "pri_fsm1");
        bus.i_fsm_req = 1'b0;
        serve(2'd2, "pri_spi0");
        serve(2'd3, "pri_poll0");
        serve(2'd2, "pri_spi1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
